l2_arbiter: RTL and testbench

Two-port arbiter in front of the shared L2 cache. Accepts line-granular miss/writeback requests from the L1 instruction cache (read-only) and the L1 data cache (read/write), grants one at a time with round-robin priority, and drives the single L2 CPU-side port. Sits between the L1 caches and `L2Cache`; the L2 controller sees exactly one requester.

---
 rtl/cache_types_pkg.sv | 19 +
 rtl/l2_arbiter_if.sv | 36 +++
 rtl/l2_arbiter.sv | 130 +++++++++++++
 tb/tb_l2_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Types and widths shared by the L1 caches, the L2 arbiter and the L2 controller.
package cache_types_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

endpackage

// File: rtl/l2_arbiter_if.sv
// L1-side request/response and L2-side command signals seen by the L2 arbiter.
interface l2_arbiter_if #(
  parameter int ADDR_W = cache_types_pkg::ADDR_W,
  parameter int LINE_W = cache_types_pkg::LINE_W
);

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  // arbiter view
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );

  // requester / L2 view
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );

endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter giving the L1 I-cache and D-cache one-at-a-time access
// to the single CPU-side port of the L2 cache.
module l2_arbiter #(
  parameter int ADDR_W = cache_types_pkg::ADDR_W,
  parameter int LINE_W = cache_types_pkg::LINE_W
) (
  input  logic        clk,
  input  logic        rst,
  l2_arbiter_if.slave bus
);

  import cache_types_pkg::*;

  localparam logic [1:0] IDLE    = 2'(ARB_IDLE);
  localparam logic [1:0] SERVE_I = 2'(ARB_SERVE_I);
  localparam logic [1:0] SERVE_D = 2'(ARB_SERVE_D);
  localparam logic [1:0] RELEASE = 2'(ARB_RELEASE);

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  requester_e        last_grant_r;
  requester_e        grant_s;
  logic              i_req_s;
  logic              d_req_s;
  logic              grant_vld_s;
  logic              i_resp_s;
  logic              d_resp_s;
  logic              l2_read_r;
  logic              l2_write_r;
  logic [ADDR_W-1:0] l2_addr_r;
  logic [LINE_W-1:0] l2_wdata_r;

  assign i_req_s     = bus.i_read;
  assign d_req_s     = bus.d_read | bus.d_write;
  assign grant_vld_s = (state_r == IDLE) && (i_req_s || d_req_s);

  // Round-robin pick: on a tie the side that was not granted last wins.
  always_comb begin
    grant_s = REQ_I;
    if (i_req_s && d_req_s) begin
      grant_s = (last_grant_r == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req_s) begin
      grant_s = REQ_D;
    end else begin
      grant_s = REQ_I;
    end
  end

  // Next-state logic and same-cycle completion pulses.
  always_comb begin
    state_s  = state_r;
    i_resp_s = 1'b0;
    d_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_vld_s) begin
          state_s = (grant_s == REQ_I) ? SERVE_I : SERVE_D;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_I: begin
        if (bus.l2_resp) begin
          i_resp_s = 1'b1;
          state_s  = RELEASE;
        end else begin
          state_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (bus.l2_resp) begin
          d_resp_s = 1'b1;
          state_s  = RELEASE;
        end else begin
          state_s = SERVE_D;
        end
      end
      RELEASE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and round-robin history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= REQ_D;
    end else begin
      state_r <= state_s;
      if (grant_vld_s) begin
        last_grant_r <= grant_s;
      end
    end
  end

  // L2 command registers: load on grant, hold through service, clear on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l2_read_r  <= 1'b0;
      l2_write_r <= 1'b0;
      l2_addr_r  <= {ADDR_W{1'b0}};
      l2_wdata_r <= {LINE_W{1'b0}};
    end else if (grant_vld_s) begin
      if (grant_s == REQ_I) begin
        l2_read_r  <= 1'b1;
        l2_write_r <= 1'b0;
        l2_addr_r  <= bus.i_addr;
      end else begin
        // a simultaneous read+write from the D-cache is taken as a writeback
        l2_read_r  <= ~bus.d_write;
        l2_write_r <= bus.d_write;
        l2_addr_r  <= bus.d_addr;
        l2_wdata_r <= bus.d_wdata;
      end
    end else if (i_resp_s || d_resp_s) begin
      l2_read_r  <= 1'b0;
      l2_write_r <= 1'b0;
    end
  end

  assign bus.l2_read  = l2_read_r;
  assign bus.l2_write = l2_write_r;
  assign bus.l2_addr  = l2_addr_r;
  assign bus.l2_wdata = l2_wdata_r;
  assign bus.i_resp   = i_resp_s;
  assign bus.d_resp   = d_resp_s;
  assign bus.i_rdata  = bus.l2_rdata;
  assign bus.d_rdata  = bus.l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_l2_arbiter;

  import cache_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_arbiter_if bus ();

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                checks   = 0;
  int                failures = 0;
  requester_e        last_srv;
  logic [LINE_W-1:0] exp_wdata;
  bit                at_release;

  always @(posedge clk) begin
    assert (!(bus.d_read && bus.d_write)) else $error("bench drove d_read and d_write together");
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    logic [ADDR_W-1:0] a;
    a      = ADDR_W'($urandom());
    a[4:0] = 5'd0;
    return a;
  endfunction

  task automatic drop_all();
    bus.i_read  = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  // One complete transaction: raise requests, expect the model's winner, hold
  // for lat cycles, complete with l2_resp, then check the RELEASE cycle.
  task automatic run_txn(input bit ri, input bit rd, input bit dw, input bit keep, input bit drop,
                         input int idle, input int lat,
                         input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                         input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rl);
    requester_e w;
    int         waited;
    int         exp_e;
    bit         want_wr;
    repeat (idle) begin @(posedge clk); #1; end
    exp_e   = (at_release && idle == 0) ? 2 : 1;
    w       = (ri && rd) ? ((last_srv == REQ_I) ? REQ_D : REQ_I) : (ri ? REQ_I : REQ_D);
    want_wr = (w == REQ_D) && dw;
    bus.i_read  = ri;
    bus.i_addr  = ia;
    bus.d_read  = rd && !dw;
    bus.d_write = rd && dw;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!(bus.l2_read || bus.l2_write) && waited < 8);
    chk("grant_latency", LINE_W'(waited), LINE_W'(exp_e));
    if (w == REQ_D) exp_wdata = wd;
    last_srv = w;
    if (drop) begin
      if (w == REQ_I) bus.i_read = 1'b0;
      else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    end
    for (int c = 1; c <= lat; c++) begin
      chk("cmd_read", LINE_W'(bus.l2_read), LINE_W'(!want_wr));
      chk("cmd_write", LINE_W'(bus.l2_write), LINE_W'(want_wr));
      chk("cmd_addr", LINE_W'(bus.l2_addr), LINE_W'((w == REQ_I) ? ia : da));
      chk("cmd_wdata", bus.l2_wdata, exp_wdata);
      chk("early_resp", LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(2'b00));
      if (c == lat) begin
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = rl;
        #1;
        chk("i_resp", LINE_W'(bus.i_resp), LINE_W'(w == REQ_I));
        chk("d_resp", LINE_W'(bus.d_resp), LINE_W'(w == REQ_D));
        chk((w == REQ_I) ? "i_rdata" : "d_rdata", (w == REQ_I) ? bus.i_rdata : bus.d_rdata, rl);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus.l2_resp  = 1'b0;
    bus.l2_rdata = rnd_line();
    if (!keep) drop_all();
    #1;
    chk("release_idle", LINE_W'({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp}), LINE_W'(4'b0000));
    at_release = 1'b1;
  endtask

  initial begin
    bit sel_i, sel_d;
    int sel;
    drop_all();
    bus.i_addr   = '0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.l2_rdata = '0;
    bus.l2_resp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", LINE_W'({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp}), LINE_W'(4'b0000));
    chk("rst_addr", LINE_W'(bus.l2_addr), '0);
    chk("rst_wdata", bus.l2_wdata, '0);
    rst = 1'b1;
    last_srv   = REQ_D;
    exp_wdata  = '0;
    at_release = 1'b0;

    // I-only read, L2 answers after 5 cycles
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 5, 32'h0000_1000, 32'h0, '0, {32{8'hAA}});
    // D-only writeback
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 3, 32'h0, 32'h0000_2000, {32{8'h55}}, rnd_line());

    // reset in the middle of a D writeback, with l2_resp high
    @(posedge clk); #1;
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_3000;
    bus.d_wdata = rnd_line();
    @(posedge clk); #1;
    chk("pre_rst_write", LINE_W'(bus.l2_write), LINE_W'(1'b1));
    #2;
    bus.l2_resp = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_cmd", LINE_W'({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp}), LINE_W'(4'b0000));
    chk("midrst_addr", LINE_W'(bus.l2_addr), '0);
    chk("midrst_wdata", bus.l2_wdata, '0);
    drop_all();
    bus.l2_resp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_srv   = REQ_D;
    exp_wdata  = '0;
    at_release = 1'b0;

    // continuous contention: I wins the first tie, then strict alternation
    for (int n = 0; n < 4; n++) begin
      run_txn(1'b1, 1'b1, n[0], (n != 3), 1'b0, 0, 2 + n, rnd_addr(), rnd_addr(), rnd_line(), rnd_line());
    end

    // D drops its request while L2 is still busy
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 4, 32'h0, rnd_addr(), rnd_line(), rnd_line());
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, rnd_addr(), 32'h0, '0, rnd_line());

    // spurious l2_resp while idle
    @(posedge clk); #1;
    bus.l2_resp = 1'b1;
    #1;
    chk("spurious_resp", LINE_W'({bus.i_resp, bus.d_resp}), LINE_W'(2'b00));
    @(posedge clk); #1;
    bus.l2_resp = 1'b0;
    chk("spurious_cmd", LINE_W'({bus.l2_read, bus.l2_write}), LINE_W'(2'b00));
    at_release = 1'b0;
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2, rnd_addr(), rnd_addr(), rnd_line(), rnd_line());

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      sel   = $urandom_range(1, 3);
      sel_i = sel[0];
      sel_d = sel[1];
      run_txn(sel_i, sel_d, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), $urandom_range(1, 6),
              rnd_addr(), rnd_addr(), rnd_line(), rnd_line());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
